// File: rtl/player_plot_scheduler_pkg.sv
// Shared definitions for the player plot scheduler: FSM state encoding, default
// screen geometry and the {x,y} position packing used by game and vga glue.
package player_plot_scheduler_pkg;

  typedef enum logic {
    ST_SCAN  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_NUM_PLAYERS = 4;
  localparam int DEF_X_W         = 8;
  localparam int DEF_Y_W         = 7;
  localparam int DEF_COLOUR_W    = 3;
  localparam int DEF_SCREEN_W    = 160;
  localparam int DEF_SCREEN_H    = 120;

  // Position words are {x, y}, x in the upper bits.
  function automatic logic [DEF_X_W+DEF_Y_W-1:0] pack_xy(input logic [DEF_X_W-1:0] x,
                                                         input logic [DEF_Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/player_plot_scheduler_sweep_counter.sv
// Raster counter for the screen-clear sweep: walks x then y across the screen and
// flags the final pixel. Exposes the next coordinate so the caller can register it.
module plot_sweep_counter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           start,
  input  logic           en,
  output logic [X_W-1:0] nxt_sx,
  output logic [Y_W-1:0] nxt_sy,
  output logic           done
);

  localparam logic [X_W-1:0] SX_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SY_MAX = Y_W'(SCREEN_H - 1);

  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;

  always_comb begin
    nxt_sx = (sx == SX_MAX) ? '0 : sx + 1'b1;
    nxt_sy = sy;
    if (sx == SX_MAX) nxt_sy = (sy == SY_MAX) ? '0 : sy + 1'b1;
  end

  assign done = (sx == SX_MAX) && (sy == SY_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn || start) begin
      sx <= '0;
      sy <= '0;
    end else if (en) begin
      sx <= nxt_sx;
      sy <= nxt_sy;
    end
  end

endmodule

// File: rtl/player_plot_scheduler.sv
// Round-robin plot scheduler: scans player position words, emits one plot per cycle
// for live players whose position moved, and can sweep the whole screen to BG_COLOUR.
module player_plot_scheduler
  import player_plot_scheduler_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int COLOUR_W    = DEF_COLOUR_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BG_COLOUR   = 0
) (
  input  logic                             CLOCK_50,
  input  logic                             resetn,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] pos_flat,
  input  logic [NUM_PLAYERS*COLOUR_W-1:0]  colour_flat,
  input  logic [NUM_PLAYERS-1:0]           alive,
  input  logic                             clear_req,
  input  logic                             plot_ready,
  output logic [X_W-1:0]                   x,
  output logic [Y_W-1:0]                   y,
  output logic [COLOUR_W-1:0]              colour,
  output logic                             plot,
  output logic                             clearing
);

  localparam int PW    = X_W + Y_W;
  localparam int PTR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [PTR_W-1:0]    PTR_MAX = PTR_W'(NUM_PLAYERS - 1);
  localparam logic [COLOUR_W-1:0] BG      = COLOUR_W'(BG_COLOUR);

  logic [PW-1:0]       pos_w [NUM_PLAYERS];
  logic [COLOUR_W-1:0] col_w [NUM_PLAYERS];

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_unpack
    assign pos_w[i] = pos_flat[i*PW +: PW];
    assign col_w[i] = colour_flat[i*COLOUR_W +: COLOUR_W];
  end

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       ptr, ptr_nxt;
  logic [PW-1:0]          last_pos [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] last_valid;

  logic [X_W-1:0]      x_nxt, sweep_nxt_x;
  logic [Y_W-1:0]      y_nxt, sweep_nxt_y;
  logic [COLOUR_W-1:0] colour_nxt;
  logic                plot_nxt;
  logic                stalled, hit, take_slot, drop_slot, clear_all;
  logic                sweep_start, sweep_en, sweep_done;

  // A pending plot the sink has not taken freezes every piece of state.
  assign stalled = plot & ~plot_ready;
  assign hit     = alive[ptr] & (~last_valid[ptr] | (pos_w[ptr] != last_pos[ptr]));

  plot_sweep_counter #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweep (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (sweep_start),
    .en       (sweep_en),
    .nxt_sx   (sweep_nxt_x),
    .nxt_sy   (sweep_nxt_y),
    .done     (sweep_done)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= ST_SCAN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!stalled) begin
      case (state)
        ST_SCAN:  if (clear_req)  state_nxt = ST_CLEAR;
        ST_CLEAR: if (sweep_done) state_nxt = ST_SCAN;
        default:                  state_nxt = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    clearing = (state == ST_CLEAR);
  end

  // NOTE: every signal gets a default before the branches so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    x_nxt       = x;
    y_nxt       = y;
    colour_nxt  = colour;
    plot_nxt    = plot;
    ptr_nxt     = ptr;
    take_slot   = 1'b0;
    drop_slot   = 1'b0;
    clear_all   = 1'b0;
    sweep_start = 1'b0;
    sweep_en    = 1'b0;
    if (!stalled) begin
      if (state == ST_SCAN) begin
        if (clear_req) begin
          // Clear wins over a simultaneous hit; the slot is left unconsumed.
          x_nxt       = '0;
          y_nxt       = '0;
          colour_nxt  = BG;
          plot_nxt    = 1'b1;
          sweep_start = 1'b1;
        end else begin
          plot_nxt  = hit;
          take_slot = hit;
          drop_slot = ~alive[ptr];
          ptr_nxt   = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
          if (hit) begin
            x_nxt      = pos_w[ptr][PW-1 -: X_W];
            y_nxt      = pos_w[ptr][Y_W-1:0];
            colour_nxt = col_w[ptr];
          end
        end
      end else begin
        // plot is always high in CLEAR, so not stalled means this pixel was accepted.
        if (sweep_done) begin
          plot_nxt  = 1'b0;
          clear_all = 1'b1;
          ptr_nxt   = '0;
        end else begin
          sweep_en = 1'b1;
          x_nxt    = sweep_nxt_x;
          y_nxt    = sweep_nxt_y;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      ptr        <= '0;
      last_valid <= '0;
    end else begin
      x      <= x_nxt;
      y      <= y_nxt;
      colour <= colour_nxt;
      plot   <= plot_nxt;
      ptr    <= ptr_nxt;
      if (clear_all)      last_valid          <= '0;
      else if (take_slot) last_valid[ptr]     <= 1'b1;
      else if (drop_slot) last_valid[ptr]     <= 1'b0;
    end
  end

  // NOTE: last_pos needs no reset; it is only read while its last_valid bit is set.
  always_ff @(posedge CLOCK_50) begin
    if (take_slot) last_pos[ptr] <= pos_w[ptr];
  end

endmodule

// File: tb/tb_player_plot_scheduler.sv
// Self-checking bench for player_plot_scheduler: directed scenarios plus randomized
// traffic, compared against a cycle-level behavioural model of the scheduler.
module tb_player_plot_scheduler;
  import player_plot_scheduler_pkg::*;

  localparam int NP = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int PW = XW + YW;
  localparam int SW = 160;
  localparam int SH = 120;

  logic             CLOCK_50 = 1'b0;
  logic             resetn;
  logic [NP*PW-1:0] pos_flat;
  logic [NP*CW-1:0] colour_flat;
  logic [NP-1:0]    alive;
  logic             clear_req;
  logic             plot_ready;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [CW-1:0]    colour;
  logic             plot;
  logic             clearing;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [CW-1:0] m_col;
  logic          m_plot, m_clearing;
  int            m_ptr, m_pix;
  logic [PW-1:0] m_last [NP];
  bit            m_lv [NP];

  always #10 CLOCK_50 = ~CLOCK_50;

  player_plot_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .pos_flat    (pos_flat),
    .colour_flat (colour_flat),
    .alive       (alive),
    .clear_req   (clear_req),
    .plot_ready  (plot_ready),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .clearing    (clearing)
  );

  function automatic logic [PW-1:0] pos_of(input int i);
    return pos_flat[i*PW +: PW];
  endfunction

  function automatic logic [CW-1:0] col_of(input int i);
    return colour_flat[i*CW +: CW];
  endfunction

  function automatic logic [PW+CW+1:0] dut_word();
    return {plot, clearing, x, y, colour};
  endfunction

  function automatic logic [PW+CW+1:0] model_word();
    return {m_plot, m_clearing, m_x, m_y, m_col};
  endfunction

  task automatic set_player(input int i, input logic [XW-1:0] xx, input logic [YW-1:0] yy,
                            input logic [CW-1:0] c);
    pos_flat[i*PW +: PW]    = pack_xy(xx, yy);
    colour_flat[i*CW +: CW] = c;
  endtask

  // Advance the model by one clock using the inputs as they stand, then step the DUT.
  task automatic tick();
    logic [PW-1:0] p;
    bit            h;
    if (!resetn) begin
      m_x = '0; m_y = '0; m_col = '0; m_plot = 1'b0; m_clearing = 1'b0; m_ptr = 0;
      foreach (m_lv[i]) m_lv[i] = 1'b0;
    end else if (m_plot && !plot_ready) begin
      // stalled: nothing moves
    end else if (m_clearing) begin
      if (m_pix == SW*SH - 1) begin
        m_clearing = 1'b0; m_plot = 1'b0; m_ptr = 0;
        foreach (m_lv[i]) m_lv[i] = 1'b0;
      end else begin
        m_pix = m_pix + 1;
        m_x   = XW'(m_pix % SW);
        m_y   = YW'(m_pix / SW);
      end
    end else if (clear_req) begin
      m_clearing = 1'b1; m_pix = 0;
      m_x = '0; m_y = '0; m_col = '0; m_plot = 1'b1;
    end else begin
      p = pos_of(m_ptr);
      if (!alive[m_ptr]) m_lv[m_ptr] = 1'b0;
      h = alive[m_ptr] && (!m_lv[m_ptr] || p != m_last[m_ptr]);
      m_plot = h;
      if (h) begin
        m_x = p[PW-1 -: XW];
        m_y = p[YW-1:0];
        m_col = col_of(m_ptr);
        m_last[m_ptr] = p;
        m_lv[m_ptr] = 1'b1;
      end
      m_ptr = (m_ptr + 1) % NP;
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; clear_req = 1'b0; plot_ready = 1'b1; alive = '1;
    for (int i = 0; i < NP; i++)
      set_player(i, XW'(i*40 + $urandom_range(39)), YW'($urandom_range(119)), CW'($urandom));
    repeat (2) tick();
    checks++;
    if ({plot, clearing, x, y, colour} !== '0) begin
      errors++;
      $display("FAIL reset_state: got plot=%0b clr=%0b x=%0d y=%0d c=%0d, want all 0",
               plot, clearing, x, y, colour);
    end
    resetn = 1'b1;
  endtask

  task automatic test_initial_plots();
    for (int k = 0; k < NP; k++) begin
      tick();
      checks++;
      if ({plot, x, y, colour} !== {1'b1, pos_of(k), col_of(k)}) begin
        errors++;
        $display("FAIL initial_plot_p%0d: got plot=%0b xy=%h c=%0d, want plot=1 xy=%h c=%0d",
                 k, plot, {x, y}, colour, pos_of(k), col_of(k));
      end
    end
  endtask

  task automatic test_static();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (plot !== 1'b0) begin
        errors++;
        $display("FAIL static_no_plot cycle %0d: got plot=%0b, want 0", c, plot);
      end
    end
  endtask

  task automatic test_change();
    int n = 0;
    bit seen = 1'b0;
    set_player(2, 8'd10, 7'd20, 3'b100);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (plot) begin
        n++;
        if ({x, y, colour} === {8'd10, 7'd20, 3'b100}) seen = 1'b1;
      end
    end
    checks++;
    if (n != 1 || !seen) begin
      errors++;
      $display("FAIL change_p2: got %0d plots (match=%0b), want exactly 1 of (10,20,100)", n, seen);
    end
    repeat (4) begin
      tick();
      if (plot) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL change_p2_once: got %0d plots over 8 cycles, want 1", n);
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    logic [PW+CW:0] held;
    set_player(1, 8'd200, 7'd99, 3'b010);
    for (int c = 0; c < 8 && !found; c++) begin
      tick();
      if (plot) found = 1'b1;
    end
    checks++;
    if (!found || {x, y, colour} !== {8'd200, 7'd99, 3'b010}) begin
      errors++;
      $display("FAIL stall_setup: got found=%0b x=%0d y=%0d c=%0d, want p1 (200,99,010)",
               found, x, y, colour);
    end
    held = {plot, x, y, colour};
    plot_ready = 1'b0;
    set_player(2, 8'd55, 7'd66, 3'b001);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({plot, x, y, colour} !== held) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got %h, want %h", c, {plot, x, y, colour}, held);
      end
    end
    plot_ready = 1'b1;
    tick();
    checks++;
    if ({plot, x, y, colour} !== {1'b1, 8'd55, 7'd66, 3'b001}) begin
      errors++;
      $display("FAIL stall_resume_next_slot: got plot=%0b x=%0d y=%0d c=%0d, want p2 (55,66,001)",
               plot, x, y, colour);
    end
    tick();
    checks++;
    if (dut_word() !== model_word()) begin
      errors++;
      $display("FAIL stall_after: got %h, want %h", dut_word(), model_word());
    end
  endtask

  task automatic test_revival();
    int n = 0;
    alive[0] = 1'b0;
    repeat (8) tick();
    alive[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (plot && {x, y} === pos_of(0)) n++;
      checks++;
      if (dut_word() !== model_word()) begin
        errors++;
        $display("FAIL revival_model cycle %0d: got %h, want %h", c, dut_word(), model_word());
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL revival_replot: got %0d plots of p0, want 1", n);
    end
  endtask

  task automatic test_clear();
    int acc = 0, bad_order = 0, bad_col = 0, bad_model = 0;
    logic [PW-1:0] last_xy = '0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if ({plot, clearing, x, y, colour} !== {1'b1, 1'b1, 8'd0, 7'd0, 3'd0}) begin
      errors++;
      $display("FAIL clear_start: got plot=%0b clr=%0b x=%0d y=%0d c=%0d, want 1 1 0 0 0",
               plot, clearing, x, y, colour);
    end
    for (int c = 0; c < 60000 && clearing; c++) begin
      plot_ready = ($urandom_range(3) != 0);
      if (plot && plot_ready) begin
        if (x !== XW'(acc % SW) || y !== YW'(acc / SW)) bad_order++;
        if (colour !== 3'd0) bad_col++;
        last_xy = {x, y};
        acc++;
      end
      tick();
      if (dut_word() !== model_word()) bad_model++;
    end
    plot_ready = 1'b1;
    checks++;
    if (acc != SW*SH) begin
      errors++;
      $display("FAIL clear_accepts: got %0d, want %0d", acc, SW*SH);
    end
    checks++;
    if (bad_order != 0 || bad_col != 0) begin
      errors++;
      $display("FAIL clear_raster: got %0d order and %0d colour errors, want 0", bad_order, bad_col);
    end
    checks++;
    if (last_xy !== {8'd159, 7'd119}) begin
      errors++;
      $display("FAIL clear_last_pixel: got %h, want %h", last_xy, {8'd159, 7'd119});
    end
    checks++;
    if ({plot, clearing} !== 2'b00 || bad_model != 0) begin
      errors++;
      $display("FAIL clear_exit: got plot=%0b clr=%0b model_diffs=%0d, want 0 0 0",
               plot, clearing, bad_model);
    end
    for (int k = 0; k < NP; k++) begin
      tick();
      checks++;
      if ({plot, x, y, colour} !== {1'b1, pos_of(k), col_of(k)}) begin
        errors++;
        $display("FAIL clear_replot_p%0d: got plot=%0b xy=%h, want plot=1 xy=%h",
                 k, plot, {x, y}, pos_of(k));
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    plot_ready = 1'b1;
    repeat (500) tick();
    checks++;
    if ({clearing, x, y} !== {1'b1, 8'd20, 7'd3}) begin
      errors++;
      $display("FAIL sweep_pixel_500: got clr=%0b x=%0d y=%0d, want 1 20 3", clearing, x, y);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if ({plot, clearing} !== 2'b00) begin
      errors++;
      $display("FAIL mid_sweep_reset: got plot=%0b clr=%0b, want 0 0", plot, clearing);
    end
    resetn = 1'b1;
    for (int k = 0; k < NP; k++) begin
      tick();
      checks++;
      if ({plot, x, y, colour} !== {1'b1, pos_of(k), col_of(k)}) begin
        errors++;
        $display("FAIL reset_replot_p%0d: got plot=%0b xy=%h, want plot=1 xy=%h",
                 k, plot, {x, y}, pos_of(k));
      end
    end
  endtask

  task automatic test_random();
    int j;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0)
        set_player($urandom_range(NP-1), XW'($urandom), YW'($urandom), CW'($urandom));
      if ($urandom_range(15) == 0) begin
        j = $urandom_range(NP-1);
        alive[j] = ~alive[j];
      end
      plot_ready = ($urandom_range(3) != 0);
      tick();
      checks++;
      if (dut_word() !== model_word()) begin
        errors++;
        $display("FAIL random_model cycle %0d: got {plot,clr,x,y,c}=%h, want %h",
                 c, dut_word(), model_word());
      end
    end
    alive = '1;
    plot_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_initial_plots();
    test_static();
    test_change();
    test_stall();
    test_revival();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
